// File: rtl/mp_ram_pkg.sv
// Shared definitions for the mp_ram_arb shared-memory block.
//   DATA_W / BE_W        : word and byte-enable widths
//   FLAG_ADDR_DEF        : default byte address of the completion-flag mailbox word
//   RESULT_ADDR_DEF      : default byte address of the result mailbox word
//   rsp_t                : per-port response register (valid, err, rdata)
//   apply_be()           : byte-lane merge used by storage and mailbox writes
package mp_ram_pkg;

  localparam int DATA_W = 32;
  localparam int BE_W   = 4;

  localparam logic [31:0] FLAG_ADDR_DEF   = 32'h0000_0FF8;
  localparam logic [31:0] RESULT_ADDR_DEF = 32'h0000_0FFC;

  typedef struct packed {
    logic              valid;
    logic              err;
    logic [DATA_W-1:0] rdata;
  } rsp_t;

  // Replace only the byte lanes whose enable bit is set.
  function automatic logic [DATA_W-1:0] apply_be(input logic [DATA_W-1:0] old_w,
                                                 input logic [DATA_W-1:0] new_w,
                                                 input logic [BE_W-1:0]   be);
    logic [DATA_W-1:0] mask;
    mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    return (new_w & mask) | (old_w & ~mask);
  endfunction

endpackage

// File: rtl/mp_ram_arb_if.sv
// Per-port request/response bus between N_PORTS cores and mp_ram_arb.
//   req_i    : per-port request           gnt_o    : per-port grant (one-hot or zero)
//   addr_i   : byte addresses, port p at [32p+31:32p]
//   we_i     : write enable               be_i     : byte enables, port p at [4p+3:4p]
//   wdata_i  : write data                 rdata_o  : read data (qualified by rvalid_o)
//   rvalid_o : response valid             err_o    : response error (qualified by rvalid_o)
// Modports: master (cores / bench), slave (memory).
interface mp_ram_arb_if
  import mp_ram_pkg::*;
#(
  parameter int N_PORTS = 2
);

  logic [N_PORTS-1:0]        req_i;
  logic [N_PORTS-1:0]        gnt_o;
  logic [N_PORTS-1:0]        rvalid_o;
  logic [N_PORTS-1:0]        err_o;
  logic [N_PORTS-1:0]        we_i;
  logic [DATA_W*N_PORTS-1:0] addr_i;
  logic [BE_W*N_PORTS-1:0]   be_i;
  logic [DATA_W*N_PORTS-1:0] wdata_i;
  logic [DATA_W*N_PORTS-1:0] rdata_o;

  modport master (
    output req_i, we_i, addr_i, be_i, wdata_i,
    input  gnt_o, rvalid_o, err_o, rdata_o
  );

  modport slave (
    input  req_i, we_i, addr_i, be_i, wdata_i,
    output gnt_o, rvalid_o, err_o, rdata_o
  );

endinterface

// File: rtl/mp_ram_rr_arb.sv
// Round-robin arbiter with a registered priority pointer.
//   clk_i, rst_i : clock, synchronous active-high reset (pointer -> 0)
//   req_i        : per-port requests
//   advance_i    : a grant was issued this cycle; move pointer past the winner
//   gnt_o        : one-hot grant (zero when nothing requests)
//   gnt_idx_o    : index of the granted port (0 when nothing granted)
module mp_ram_rr_arb #(
  parameter  int N_PORTS = 2,
  localparam int IDX_W   = (N_PORTS > 1) ? $clog2(N_PORTS) : 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [N_PORTS-1:0] req_i,
  input  logic               advance_i,
  output logic [N_PORTS-1:0] gnt_o,
  output logic [IDX_W-1:0]   gnt_idx_o
);

  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] ptr_d;
  logic             found;

  // Scan from the pointer upward, wrapping; first requester wins.
  always_comb begin
    int cand;
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    cand      = 0;
    for (int i = 0; i < N_PORTS; i++) begin
      cand = (int'(ptr_q) + i) % N_PORTS;
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        gnt_idx_o   = IDX_W'(cand);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance_i) begin
      ptr_d = (int'(gnt_idx_o) == N_PORTS - 1) ? '0 : gnt_idx_o + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/mp_ram_arb.sv
// N-port word memory: single-ported storage behind a round-robin arbiter,
// one access per cycle, response one cycle after the grant.
//   clk_i, rst_i   : clock, synchronous active-high reset
//   bus            : mp_ram_arb_if.slave request/response bus
//   mem_flag_o     : registered copy of the word at FLAG_ADDR
//   mem_result_o   : registered copy of the word at RESULT_ADDR
//   conflict_cnt_o : (MP_RAM_CONTENTION_STATS_EN only) per-port 16-bit saturating
//                    count of cycles spent requesting without a grant
// Optional feature macro: MP_RAM_CONTENTION_STATS_EN.
module mp_ram_arb
  import mp_ram_pkg::*;
#(
  parameter int          N_PORTS     = 2,
  parameter int          MEM_WORDS   = 1024,
  parameter logic [31:0] FLAG_ADDR   = FLAG_ADDR_DEF,
  parameter logic [31:0] RESULT_ADDR = RESULT_ADDR_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  mp_ram_arb_if.slave       bus,
  output logic [DATA_W-1:0] mem_flag_o,
  output logic [DATA_W-1:0] mem_result_o
`ifdef MP_RAM_CONTENTION_STATS_EN
  ,
  output logic [16*N_PORTS-1:0] conflict_cnt_o
`endif
);

  localparam int IDX_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam int AW    = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  logic [N_PORTS-1:0] req_m;
  logic [N_PORTS-1:0] gnt;
  logic [IDX_W-1:0]   gidx;
  logic               acc;

  logic [DATA_W-1:0]  g_addr;
  logic [DATA_W-1:0]  g_wdata;
  logic [BE_W-1:0]    g_be;
  logic               g_we;
  logic [29:0]        word;
  logic               in_rng;
  logic [AW-1:0]      widx;
  logic [DATA_W-1:0]  rd_word;
  logic [DATA_W-1:0]  rd_val;
  logic               wr_en;
  logic               unused_addr_lsb;

  logic [DATA_W-1:0]  mem_q [MEM_WORDS];
  rsp_t               rsp_q [N_PORTS];
  rsp_t               rsp_d [N_PORTS];
  logic [DATA_W-1:0]  flag_q, flag_d;
  logic [DATA_W-1:0]  result_q, result_d;

  logic [N_PORTS-1:0]        rvalid_v;
  logic [N_PORTS-1:0]        err_v;
  logic [DATA_W*N_PORTS-1:0] rdata_v;

  // Requests are masked during reset so no grant (and no write) can happen.
  assign req_m = bus.req_i & {N_PORTS{~rst_i}};

  mp_ram_rr_arb #(.N_PORTS(N_PORTS)) u_arb (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .req_i     (req_m),
    .advance_i (acc),
    .gnt_o     (gnt),
    .gnt_idx_o (gidx)
  );

  assign acc       = |gnt;
  assign bus.gnt_o = gnt;

  // Attributes of the granted port.
  assign g_addr  = bus.addr_i[DATA_W*int'(gidx) +: DATA_W];
  assign g_wdata = bus.wdata_i[DATA_W*int'(gidx) +: DATA_W];
  assign g_be    = bus.be_i[BE_W*int'(gidx) +: BE_W];
  assign g_we    = bus.we_i[gidx];

  assign unused_addr_lsb = ^g_addr[1:0];
  assign word            = g_addr[31:2];
  assign in_rng          = {2'b00, word} < 32'(MEM_WORDS);
  assign widx            = word[AW-1:0];
  assign rd_word         = mem_q[widx];
  assign rd_val          = (in_rng && !g_we) ? rd_word : '0;
  assign wr_en           = acc && g_we && in_rng;

  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem_q[widx] <= apply_be(mem_q[widx], g_wdata, g_be);
    end
  end

  // Only the granted port's rdata is refreshed; other ports keep their last value.
  always_comb begin
    for (int p = 0; p < N_PORTS; p++) begin
      rsp_d[p].valid = gnt[p];
      rsp_d[p].err   = gnt[p] & ~in_rng;
      rsp_d[p].rdata = gnt[p] ? rd_val : rsp_q[p].rdata;
    end
  end

  always_comb begin
    flag_d   = flag_q;
    result_d = result_q;
    if (wr_en && (word == FLAG_ADDR[31:2])) begin
      flag_d = apply_be(flag_q, g_wdata, g_be);
    end
    if (wr_en && (word == RESULT_ADDR[31:2])) begin
      result_d = apply_be(result_q, g_wdata, g_be);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int p = 0; p < N_PORTS; p++) begin
        rsp_q[p] <= '0;
      end
      flag_q   <= '0;
      result_q <= '0;
    end else begin
      for (int p = 0; p < N_PORTS; p++) begin
        rsp_q[p] <= rsp_d[p];
      end
      flag_q   <= flag_d;
      result_q <= result_d;
    end
  end

  // A response due in a reset cycle is dropped, hence the rst_i mask.
  always_comb begin
    rvalid_v = '0;
    err_v    = '0;
    rdata_v  = '0;
    for (int p = 0; p < N_PORTS; p++) begin
      rvalid_v[p]                  = rsp_q[p].valid & ~rst_i;
      err_v[p]                     = rsp_q[p].err & ~rst_i;
      rdata_v[DATA_W*p +: DATA_W]  = rsp_q[p].rdata;
    end
  end

  assign bus.rvalid_o  = rvalid_v;
  assign bus.err_o     = err_v;
  assign bus.rdata_o   = rdata_v;
  assign mem_flag_o    = flag_q;
  assign mem_result_o  = result_q;

`ifdef MP_RAM_CONTENTION_STATS_EN
  logic [15:0] cnt_q [N_PORTS];
  logic [15:0] cnt_d [N_PORTS];

  always_comb begin
    for (int p = 0; p < N_PORTS; p++) begin
      cnt_d[p] = cnt_q[p];
      if (bus.req_i[p] && !gnt[p] && (cnt_q[p] != 16'hFFFF)) begin
        cnt_d[p] = cnt_q[p] + 16'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int p = 0; p < N_PORTS; p++) begin
        cnt_q[p] <= '0;
      end
    end else begin
      for (int p = 0; p < N_PORTS; p++) begin
        cnt_q[p] <= cnt_d[p];
      end
    end
  end

  always_comb begin
    conflict_cnt_o = '0;
    for (int p = 0; p < N_PORTS; p++) begin
      conflict_cnt_o[16*p +: 16] = cnt_q[p];
    end
  end
`endif

endmodule

// File: tb/tb_mp_ram_arb.sv
// Self-checking bench for mp_ram_arb: a 2-port and a 4-port instance share one clock.
module tb_mp_ram_arb;

  logic clk  = 1'b0;
  logic rst2 = 1'b1;
  logic rst4 = 1'b1;
  always #5 clk = ~clk;

  mp_ram_arb_if #(.N_PORTS(2)) bus2 ();
  mp_ram_arb_if #(.N_PORTS(4)) bus4 ();

  logic [31:0] flag2, res2, flag4, res4;
`ifdef MP_RAM_CONTENTION_STATS_EN
  logic [31:0] cnt2;
  logic [63:0] cnt4;
`endif

  mp_ram_arb #(.N_PORTS(2)) dut2 (
    .clk_i(clk), .rst_i(rst2), .bus(bus2), .mem_flag_o(flag2), .mem_result_o(res2)
`ifdef MP_RAM_CONTENTION_STATS_EN
    , .conflict_cnt_o(cnt2)
`endif
  );

  mp_ram_arb #(.N_PORTS(4)) dut4 (
    .clk_i(clk), .rst_i(rst4), .bus(bus4), .mem_flag_o(flag4), .mem_result_o(res4)
`ifdef MP_RAM_CONTENTION_STATS_EN
    , .conflict_cnt_o(cnt4)
`endif
  );

  typedef struct {
    int          port;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb2[$];
  exp_t sb4[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;

  logic [1:0]  g2, rv2, er2;
  logic [31:0] rd2, fl2, rs2;

  // Single-port access table: port, we, addr, be, wdata, expected err, expected rdata.
  int          t_p   [10] = '{0, 0, 1, 1, 0, 1, 0, 0, 0, 1};
  logic        t_we  [10] = '{1, 0, 1, 0, 1, 0, 1, 0, 1, 0};
  logic [31:0] t_ad  [10] = '{32'h10, 32'h10, 32'h10, 32'h10, 32'h0,
                              32'h1000, 32'h1000, 32'h0, 32'h10, 32'h13};
  logic [3:0]  t_be  [10] = '{4'hF, 4'h0, 4'b0101, 4'h0, 4'hF, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0};
  logic [31:0] t_wd  [10] = '{32'hDEAD_BEEF, 32'h0, 32'h1122_3344, 32'h0, 32'h0BAD_F00D,
                              32'h0, 32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFF, 32'h0};
  logic        t_err [10] = '{0, 0, 0, 0, 0, 1, 1, 0, 0, 0};
  logic [31:0] t_rd  [10] = '{32'h0, 32'hDEAD_BEEF, 32'h0, 32'hDE22_BE44, 32'h0,
                              32'h0, 32'h0, 32'h0BAD_F00D, 32'h0, 32'hDE22_BE44};

  task automatic idle2();
    bus2.req_i = '0; bus2.we_i = '0; bus2.be_i = '0; bus2.addr_i = '0; bus2.wdata_i = '0;
  endtask

  task automatic idle4();
    bus4.req_i = '0; bus4.we_i = '0; bus4.be_i = '0; bus4.addr_i = '0; bus4.wdata_i = '0;
  endtask

  task automatic set2(input int p, input logic we, input logic [31:0] a,
                      input logic [3:0] be, input logic [31:0] wd);
    bus2.req_i[p] = 1'b1; bus2.we_i[p] = we; bus2.addr_i[p*32 +: 32] = a;
    bus2.be_i[p*4 +: 4] = be; bus2.wdata_i[p*32 +: 32] = wd;
  endtask

  task automatic set4(input int p, input logic we, input logic [31:0] a,
                      input logic [3:0] be, input logic [31:0] wd);
    bus4.req_i[p] = 1'b1; bus4.we_i[p] = we; bus4.addr_i[p*32 +: 32] = a;
    bus4.be_i[p*4 +: 4] = be; bus4.wdata_i[p*32 +: 32] = wd;
  endtask

  // One isolated access on dut2; captures grant in the request cycle and the
  // response/mailbox one cycle later.
  task automatic acc2(input int p, input logic we, input logic [31:0] a,
                      input logic [3:0] be, input logic [31:0] wd);
    @(posedge clk); #1;
    idle2();
    set2(p, we, a, be, wd);
    @(negedge clk);
    g2 = bus2.gnt_o;
    @(posedge clk); #1;
    idle2();
    @(negedge clk);
    rv2 = bus2.rvalid_o; er2 = bus2.err_o; rd2 = bus2.rdata_o[p*32 +: 32];
    fl2 = flag2; rs2 = res2;
  endtask

  task automatic test_reset();
    rst2 = 1'b1; rst4 = 1'b1;
    idle2(); idle4();
    set2(0, 1'b0, 32'h10, 4'h0, 32'h0);
    set2(1, 1'b1, 32'h14, 4'hF, 32'h55);
    bus4.req_i = '1;
    @(posedge clk); @(posedge clk); @(negedge clk);
    checks++; if (bus2.gnt_o !== 2'b00) begin errors++; $display("FAIL reset gnt2 got %b want 00", bus2.gnt_o); end
    checks++; if (bus4.gnt_o !== 4'b0000) begin errors++; $display("FAIL reset gnt4 got %b want 0000", bus4.gnt_o); end
    checks++; if (bus2.rvalid_o !== 2'b00) begin errors++; $display("FAIL reset rvalid got %b want 00", bus2.rvalid_o); end
    checks++; if (bus2.err_o !== 2'b00) begin errors++; $display("FAIL reset err got %b want 00", bus2.err_o); end
    checks++; if (bus2.rdata_o !== 64'h0) begin errors++; $display("FAIL reset rdata got %h want 0", bus2.rdata_o); end
    checks++; if (flag2 !== 32'h0) begin errors++; $display("FAIL reset flag got %h want 0", flag2); end
    checks++; if (res2 !== 32'h0) begin errors++; $display("FAIL reset result got %h want 0", res2); end
    @(posedge clk); #1;
    rst2 = 1'b0; rst4 = 1'b0;
    idle2(); idle4();
  endtask

  // Write/read, byte enables, be=0 no-op, address LSBs ignored, out-of-range.
  task automatic test_single_port();
    logic [1:0] w;
    for (int k = 0; k < 10; k++) begin
      e.port = t_p[k]; e.err = t_err[k]; e.rdata = t_rd[k];
      sb2.push_back(e);
      acc2(t_p[k], t_we[k], t_ad[k], t_be[k], t_wd[k]);
      e = sb2.pop_front();
      w = 2'b01 << e.port;
      checks++; if (g2 !== w) begin errors++; $display("FAIL access[%0d] gnt got %b want %b", k, g2, w); end
      checks++; if (rv2 !== w) begin errors++; $display("FAIL access[%0d] rvalid got %b want %b", k, rv2, w); end
      checks++; if (er2[e.port] !== e.err) begin errors++; $display("FAIL access[%0d] err got %b want %b", k, er2[e.port], e.err); end
      checks++; if (rd2 !== e.rdata) begin errors++; $display("FAIL access[%0d] rdata got %h want %h", k, rd2, e.rdata); end
    end
  endtask

  task automatic test_mailbox();
    acc2(1, 1'b1, 32'h0000_0FF8, 4'hF, 32'd1);
    checks++; if (rv2 !== 2'b10) begin errors++; $display("FAIL mbox flag rvalid got %b want 10", rv2); end
    checks++; if (fl2 !== 32'd1) begin errors++; $display("FAIL mbox flag got %h want 1", fl2); end
    acc2(0, 1'b1, 32'h0000_0FFC, 4'hF, 32'd42);
    checks++; if (rs2 !== 32'd42) begin errors++; $display("FAIL mbox result got %h want 2a", rs2); end
    checks++; if (fl2 !== 32'd1) begin errors++; $display("FAIL mbox flag hold got %h want 1", fl2); end
    acc2(0, 1'b1, 32'h0000_0FFC, 4'b0010, 32'h0000_FF00);
    checks++; if (rs2 !== 32'h0000_FF2A) begin errors++; $display("FAIL mbox result be got %h want 0000ff2a", rs2); end
    acc2(1, 1'b0, 32'h0000_0FF8, 4'h0, 32'h0);
    checks++; if (rd2 !== 32'd1) begin errors++; $display("FAIL mbox flag read got %h want 1", rd2); end
    checks++; if (fl2 !== 32'd1) begin errors++; $display("FAIL mbox flag after read got %h want 1", fl2); end
    @(posedge clk); #1; rst2 = 1'b1;
    @(posedge clk); #1; rst2 = 1'b0;
    @(negedge clk);
    checks++; if (flag2 !== 32'h0) begin errors++; $display("FAIL mbox flag after rst got %h want 0", flag2); end
    checks++; if (res2 !== 32'h0) begin errors++; $display("FAIL mbox result after rst got %h want 0", res2); end
  endtask

  // Port 0 writes while port 1 reads the same word; the read follows and sees new data.
  task automatic test_back_to_back();
    @(posedge clk); #1; rst2 = 1'b1; idle2();
    @(posedge clk); #1; rst2 = 1'b0;
    set2(0, 1'b1, 32'h40, 4'hF, 32'hA5A5_0001);
    set2(1, 1'b0, 32'h40, 4'h0, 32'h0);
    e.port = 0; e.err = 1'b0; e.rdata = 32'h0; sb2.push_back(e);
    @(negedge clk);
    checks++; if (bus2.gnt_o !== 2'b01) begin errors++; $display("FAIL b2b gnt0 got %b want 01", bus2.gnt_o); end
    @(posedge clk); #1;
    bus2.req_i[0] = 1'b0;
    e.port = 1; e.err = 1'b0; e.rdata = 32'hA5A5_0001; sb2.push_back(e);
    @(negedge clk);
    checks++; if (bus2.gnt_o !== 2'b10) begin errors++; $display("FAIL b2b gnt1 got %b want 10", bus2.gnt_o); end
    e = sb2.pop_front();
    checks++; if (bus2.rvalid_o !== 2'b01) begin errors++; $display("FAIL b2b rvalid0 got %b want 01", bus2.rvalid_o); end
    checks++; if (bus2.rdata_o[e.port*32 +: 32] !== e.rdata) begin errors++; $display("FAIL b2b wr rdata got %h want %h", bus2.rdata_o[e.port*32 +: 32], e.rdata); end
    @(posedge clk); #1; idle2();
    @(negedge clk);
    e = sb2.pop_front();
    checks++; if (bus2.rvalid_o !== 2'b10) begin errors++; $display("FAIL b2b rvalid1 got %b want 10", bus2.rvalid_o); end
    checks++; if (bus2.rdata_o[e.port*32 +: 32] !== e.rdata) begin errors++; $display("FAIL b2b raw rdata got %h want %h", bus2.rdata_o[e.port*32 +: 32], e.rdata); end
  endtask

  task automatic test_contention();
    int gp;
    logic [3:0] w;
    for (int p = 0; p < 4; p++) begin
      @(posedge clk); #1; idle4();
      set4(p, 1'b1, 32'h20 + 32'(4*p), 4'hF, 32'hC0DE_0000 + 32'(p));
    end
    @(posedge clk); #1; idle4();
    rst4 = 1'b1;
    for (int p = 0; p < 4; p++) set4(p, 1'b0, 32'h20 + 32'(4*p), 4'h0, 32'h0);
    @(posedge clk); #1; rst4 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      gp = k % 4;
      w = 4'b0001 << gp;
      checks++; if (bus4.gnt_o !== w) begin errors++; $display("FAIL rr gnt[%0d] got %b want %b", k, bus4.gnt_o, w); end
      if (k > 0) begin
        e = sb4.pop_front();
        w = 4'b0001 << e.port;
        checks++; if (bus4.rvalid_o !== w) begin errors++; $display("FAIL rr rvalid[%0d] got %b want %b", k, bus4.rvalid_o, w); end
        checks++; if (bus4.rdata_o[e.port*32 +: 32] !== e.rdata) begin errors++; $display("FAIL rr rdata[%0d] got %h want %h", k, bus4.rdata_o[e.port*32 +: 32], e.rdata); end
      end
      e.port = gp; e.err = 1'b0; e.rdata = 32'hC0DE_0000 + 32'(gp);
      sb4.push_back(e);
    end
    @(posedge clk); #1; idle4();
    @(negedge clk);
    e = sb4.pop_front();
    w = 4'b0001 << e.port;
    checks++; if (bus4.rvalid_o !== w) begin errors++; $display("FAIL rr rvalid last got %b want %b", bus4.rvalid_o, w); end
    checks++; if (bus4.rdata_o[e.port*32 +: 32] !== e.rdata) begin errors++; $display("FAIL rr rdata last got %h want %h", bus4.rdata_o[e.port*32 +: 32], e.rdata); end
  endtask

  task automatic test_reset_mid();
    acc2(0, 1'b1, 32'h50, 4'hF, 32'h1111_1111);
    @(posedge clk); #1; idle2();
    set2(0, 1'b1, 32'h50, 4'hF, 32'h2222_2222);
    @(negedge clk);
    checks++; if (bus2.gnt_o !== 2'b01) begin errors++; $display("FAIL midrst gnt got %b want 01", bus2.gnt_o); end
    @(posedge clk); #1; idle2(); rst2 = 1'b1;
    @(negedge clk);
    checks++; if (bus2.rvalid_o !== 2'b00) begin errors++; $display("FAIL midrst rvalid got %b want 00", bus2.rvalid_o); end
    @(posedge clk); #1;
    set2(0, 1'b1, 32'h50, 4'hF, 32'h3333_3333);
    @(negedge clk);
    checks++; if (bus2.gnt_o !== 2'b00) begin errors++; $display("FAIL midrst gnt in rst got %b want 00", bus2.gnt_o); end
    @(posedge clk); #1; rst2 = 1'b0; idle2();
    acc2(1, 1'b0, 32'h50, 4'h0, 32'h0);
    checks++; if (rd2 !== 32'h2222_2222) begin errors++; $display("FAIL midrst readback got %h want 22222222", rd2); end
  endtask

`ifdef MP_RAM_CONTENTION_STATS_EN
  task automatic test_counters();
    int wait_cnt [2];
    int ptr;
    wait_cnt[0] = 0; wait_cnt[1] = 0; ptr = 0;
    for (int k = 0; k < 6; k++) begin
      wait_cnt[1 - ptr]++;
      ptr = 1 - ptr;
    end
    @(posedge clk); #1; rst2 = 1'b1; idle2();
    @(posedge clk); #1; rst2 = 1'b0;
    set2(0, 1'b0, 32'h10, 4'h0, 32'h0);
    set2(1, 1'b0, 32'h40, 4'h0, 32'h0);
    repeat (6) @(posedge clk);
    #1; idle2();
    @(negedge clk);
    checks++; if (cnt2[15:0] !== 16'(wait_cnt[0])) begin errors++; $display("FAIL cnt port0 got %0d want %0d", cnt2[15:0], wait_cnt[0]); end
    checks++; if (cnt2[31:16] !== 16'(wait_cnt[1])) begin errors++; $display("FAIL cnt port1 got %0d want %0d", cnt2[31:16], wait_cnt[1]); end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    idle2(); idle4();
    test_reset();
    test_single_port();
    test_mailbox();
    test_back_to_back();
    test_contention();
    test_reset_mid();
`ifdef MP_RAM_CONTENTION_STATS_EN
    test_counters();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
